// File: rtl/segment_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : segment_pkg
//  Purpose  : Shared seven-segment definitions. Holds the active-high digit
//             pattern table ({G,F,E,D,C,B,A}), the blank pattern, the decoder
//             FSM state encoding and a pattern-to-digit decode function.
//  Revision : 1.0 - initial release
// ============================================================================
package segment_pkg;

  // Active-high segment patterns, bit order {G,F,E,D,C,B,A}
  localparam logic [6:0] c_SEG_0     = 7'h3F;
  localparam logic [6:0] c_SEG_1     = 7'h06;
  localparam logic [6:0] c_SEG_2     = 7'h5B;
  localparam logic [6:0] c_SEG_3     = 7'h4F;
  localparam logic [6:0] c_SEG_4     = 7'h66;
  localparam logic [6:0] c_SEG_5     = 7'h6D;
  localparam logic [6:0] c_SEG_6     = 7'h7D;
  localparam logic [6:0] c_SEG_7     = 7'h07;
  localparam logic [6:0] c_SEG_8     = 7'h7F;
  localparam logic [6:0] c_SEG_9     = 7'h6F;
  localparam logic [6:0] c_SEG_A     = 7'h77;
  localparam logic [6:0] c_SEG_B     = 7'h7C;
  localparam logic [6:0] c_SEG_C     = 7'h39;
  localparam logic [6:0] c_SEG_D     = 7'h5E;
  localparam logic [6:0] c_SEG_E     = 7'h79;
  localparam logic [6:0] c_SEG_F     = 7'h71;
  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_DIGIT   = 3'd2,
    S_BLANK   = 3'd3,
    S_INVALID = 3'd4
  } state_t;

  // Returns {legal, value}. Blank and unknown patterns both return legal=0;
  // callers separate blank from invalid themselves.
  function automatic logic [4:0] decode_pattern(input logic [6:0] pattern);
    logic [4:0] result;
    result = 5'b0_0000;
    case (pattern)
      c_SEG_0: result = {1'b1, 4'h0};
      c_SEG_1: result = {1'b1, 4'h1};
      c_SEG_2: result = {1'b1, 4'h2};
      c_SEG_3: result = {1'b1, 4'h3};
      c_SEG_4: result = {1'b1, 4'h4};
      c_SEG_5: result = {1'b1, 4'h5};
      c_SEG_6: result = {1'b1, 4'h6};
      c_SEG_7: result = {1'b1, 4'h7};
      c_SEG_8: result = {1'b1, 4'h8};
      c_SEG_9: result = {1'b1, 4'h9};
      c_SEG_A: result = {1'b1, 4'hA};
      c_SEG_B: result = {1'b1, 4'hB};
      c_SEG_C: result = {1'b1, 4'hC};
      c_SEG_D: result = {1'b1, 4'hD};
      c_SEG_E: result = {1'b1, 4'hE};
      c_SEG_F: result = {1'b1, 4'hF};
      default: result = 5'b0_0000;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segment_sync.sv
`default_nettype none
// ============================================================================
//  Module   : segment_sync
//  Purpose  : Parameterized-width two-flop synchronizer with a programmable
//             reset value, so idle lines can come out of reset at their
//             physical "off" level.
//  Ports    : i_Clk   - destination clock
//             i_Rst   - asynchronous active-high reset
//             i_Async - asynchronous input vector
//             o_Sync  - synchronized output vector (two flops of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module segment_sync #(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = i_Async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_Sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : segment_decoder
//  Purpose  : Recovers a 4-bit hex digit from seven-segment drive lines.
//             Lines are synchronized, a pattern must hold for STABLE_CYCLES
//             consecutive samples, then it is decoded to a digit, blank, or
//             invalid pattern.
//  Ports    : i_Clk, i_Rst        - clock, asynchronous active-high reset
//             i_Seg_A .. i_Seg_G  - segment lines (asynchronous)
//             o_Value             - last accepted digit
//             o_Valid             - last accepted pattern was a digit
//             o_Change            - pulse: new or changed digit accepted
//             o_Invalid           - pulse: unrecognized pattern accepted
//             o_Err_Count         - saturating count of o_Invalid pulses
//  Revision : 1.0 - initial release
// ============================================================================
module segment_decoder
  import segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 250000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Seg_A,
  input  logic       i_Seg_B,
  input  logic       i_Seg_C,
  input  logic       i_Seg_D,
  input  logic       i_Seg_E,
  input  logic       i_Seg_F,
  input  logic       i_Seg_G,
  output logic [3:0] o_Value,
  output logic       o_Valid,
  output logic       o_Change,
  output logic       o_Invalid,
  output logic [7:0] o_Err_Count
);

  localparam int               CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  // --------------------------------------------------------------------------
  // Synchronize and normalize to active-high {G,F,E,D,C,B,A}
  // --------------------------------------------------------------------------
  logic [6:0] seg_raw;
  logic [6:0] seg_sync;
  logic [6:0] pattern;

  assign seg_raw = {i_Seg_G, i_Seg_F, i_Seg_E, i_Seg_D, i_Seg_C, i_Seg_B, i_Seg_A};

  segment_sync #(
    .WIDTH       (7),
    .RESET_VALUE (SEG_OFF)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (seg_raw),
    .o_Sync  (seg_sync)
  );

  generate
    if (ACTIVE_LOW) begin : g_active_low
      assign pattern = ~seg_sync;
    end else begin : g_active_high
      assign pattern = seg_sync;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_d,   state_q;
  logic [6:0]       cand_d,    cand_q;
  logic [CNT_W-1:0] cnt_d,     cnt_q;
  logic [3:0]       value_d,   value_q;
  logic             valid_d,   valid_q;
  logic             change_d,  change_q;
  logic             invalid_d, invalid_q;
  logic [7:0]       err_d,     err_q;

  logic [4:0] cand_dec;
  logic       cand_legal;
  logic [3:0] cand_value;
  logic       settling;

  assign cand_dec   = decode_pattern(cand_q);
  assign cand_legal = cand_dec[4];
  assign cand_value = cand_dec[3:0];
  // S_IDLE is just a settle phase whose candidate starts out blank
  assign settling   = (state_q == S_IDLE) || (state_q == S_SETTLE);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    change_d  = 1'b0;
    invalid_d = 1'b0;
    err_d     = err_q;

    if (pattern != cand_q) begin
      // A new pattern always wins, even on the cycle the count saturates
      cand_d  = pattern;
      cnt_d   = '0;
      state_d = S_SETTLE;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (settling && (cnt_q == CNT_MAX)) begin
        if (cand_q == c_SEG_BLANK) begin
          state_d = S_BLANK;
          valid_d = 1'b0;
        end else if (cand_legal) begin
          state_d  = S_DIGIT;
          value_d  = cand_value;
          valid_d  = 1'b1;
          // valid_q low means the previous decision was blank/invalid/reset
          change_d = !valid_q || (value_q != cand_value);
        end else begin
          state_d   = S_INVALID;
          valid_d   = 1'b0;
          invalid_d = 1'b1;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cand_q    <= c_SEG_BLANK;
      cnt_q     <= '0;
      value_q   <= 4'h0;
      valid_q   <= 1'b0;
      change_q  <= 1'b0;
      invalid_q <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      change_q  <= change_d;
      invalid_q <= invalid_d;
      err_q     <= err_d;
    end
  end

  assign o_Value     = value_q;
  assign o_Valid     = valid_q;
  assign o_Change    = change_q;
  assign o_Invalid   = invalid_q;
  assign o_Err_Count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segment_decoder
//  Purpose  : Self-checking bench for segment_decoder with STABLE_CYCLES=4,
//             ACTIVE_LOW=1. Table of directed patterns plus hand-written
//             sequences for reset, glitch, saturation and boundary cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segment_decoder;

  logic       clk;
  logic       rst;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [3:0] value;
  logic       valid;
  logic       change;
  logic       invalid;
  logic [7:0] err_count;

  segment_decoder #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Seg_A     (seg_a),
    .i_Seg_B     (seg_b),
    .i_Seg_C     (seg_c),
    .i_Seg_D     (seg_d),
    .i_Seg_E     (seg_e),
    .i_Seg_F     (seg_f),
    .i_Seg_G     (seg_g),
    .o_Value     (value),
    .o_Valid     (valid),
    .o_Change    (change),
    .o_Invalid   (invalid),
    .o_Err_Count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_change  = 0;
  int n_invalid = 0;
  always @(negedge clk) begin
    if (change)  n_change  <= n_change + 1;
    if (invalid) n_invalid <= n_invalid + 1;
  end

  typedef struct packed {
    logic [6:0] pat;      // active-high {G..A}
    logic [3:0] value;
    logic       valid;
    logic       change;
    logic       invalid;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] p);
    {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = ~p;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] prev_value;
  logic       prev_valid;
  int         exp_err;
  int         snap;
  int         snap_inv;

  initial begin
    vecs[0]  = '{7'h3F, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{7'h06, 4'h1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{7'h5B, 4'h2, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{7'h4F, 4'h3, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{7'h66, 4'h4, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{7'h6D, 4'h5, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{7'h7D, 4'h6, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{7'h07, 4'h7, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{7'h7F, 4'h8, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{7'h6F, 4'h9, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{7'h77, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{7'h7C, 4'hB, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{7'h39, 4'hC, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{7'h5E, 4'hD, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{7'h79, 4'hE, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{7'h71, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{7'h01, 4'hF, 1'b0, 1'b0, 1'b1};  // A only: invalid, value holds
    vecs[17] = '{7'h00, 4'hF, 1'b0, 1'b0, 1'b0};  // blank
    vecs[18] = '{7'h4F, 4'h3, 1'b1, 1'b1, 1'b0};  // 3 after blank
    vecs[19] = '{7'h00, 4'h3, 1'b0, 1'b0, 1'b0};  // blank
    vecs[20] = '{7'h4F, 4'h3, 1'b1, 1'b1, 1'b0};  // 3 again: pulses again
    vecs[21] = '{7'h7F, 4'h8, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{7'h49, 4'h8, 1'b0, 1'b0, 1'b1};  // A,D,G: invalid
    vecs[23] = '{7'h7F, 4'h8, 1'b1, 1'b1, 1'b0};  // same digit after invalid

    // ---------------- reset ----------------
    rst = 1'b0;
    drive(7'h00);
    #1 rst = 1'b1;
    #1;
    chk("reset_value",   {28'd0, value},   32'd0);
    chk("reset_valid",   {31'd0, valid},   32'd0);
    chk("reset_change",  {31'd0, change},  32'd0);
    chk("reset_invalid", {31'd0, invalid}, 32'd0);
    chk("reset_err",     {24'd0, err_count}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick(20);
    chk("blank_hold_valid",   {31'd0, valid}, 32'd0);
    chk("blank_hold_value",   {28'd0, value}, 32'd0);
    chk("blank_hold_changes", n_change,  0);
    chk("blank_hold_invalid", n_invalid, 0);

    // ---------------- digit accept, exact latency ----------------
    drive(7'h6D);
    tick(6);
    chk("d5_early_valid",  {31'd0, valid},  32'd0);
    chk("d5_early_change", {31'd0, change}, 32'd0);
    tick(1);
    chk("d5_value",  {28'd0, value},  32'd5);
    chk("d5_valid",  {31'd0, valid},  32'd1);
    chk("d5_change", {31'd0, change}, 32'd1);
    tick(1);
    chk("d5_change_done", {31'd0, change}, 32'd0);

    // ---------------- short glitch to 8 ----------------
    snap = n_change;
    drive(7'h7F);
    tick(2);
    drive(7'h6D);
    tick(15);
    chk("glitch_value",   {28'd0, value}, 32'd5);
    chk("glitch_valid",   {31'd0, valid}, 32'd1);
    chk("glitch_changes", n_change - snap, 0);

    // ---------------- table vectors ----------------
    prev_value = 4'h5;
    prev_valid = 1'b1;
    exp_err    = 0;
    snap       = n_change;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].pat);
      tick(6);
      chk("hold_value",   {28'd0, value},   {28'd0, prev_value});
      chk("hold_valid",   {31'd0, valid},   {31'd0, prev_valid});
      chk("hold_change",  {31'd0, change},  32'd0);
      chk("hold_invalid", {31'd0, invalid}, 32'd0);
      tick(1);
      if (vecs[i].invalid && exp_err < 255) exp_err++;
      chk("vec_value",   {28'd0, value},   {28'd0, vecs[i].value});
      chk("vec_valid",   {31'd0, valid},   {31'd0, vecs[i].valid});
      chk("vec_change",  {31'd0, change},  {31'd0, vecs[i].change});
      chk("vec_invalid", {31'd0, invalid}, {31'd0, vecs[i].invalid});
      chk("vec_err",     {24'd0, err_count}, exp_err);
      tick(1);
      chk("vec_change_done",  {31'd0, change},  32'd0);
      chk("vec_invalid_done", {31'd0, invalid}, 32'd0);
      if (i == 15) begin
        chk("sweep_changes", n_change - snap, 16);
        chk("sweep_err",     {24'd0, err_count}, 32'd0);
      end
      prev_value = vecs[i].value;
      prev_valid = vecs[i].valid;
    end

    // ---------------- error counter saturation ----------------
    snap_inv = n_invalid;
    for (int k = 0; k < 300; k++) begin
      drive((k % 2 == 0) ? 7'h01 : 7'h02);
      tick(8);
    end
    chk("sat_pulses", n_invalid - snap_inv, 300);
    chk("sat_err",    {24'd0, err_count}, 32'd255);
    chk("sat_value",  {28'd0, value}, 32'd8);
    chk("sat_valid",  {31'd0, valid}, 32'd0);

    // ---------------- change on the saturation cycle ----------------
    drive(7'h5B);          // edge 0
    tick(4);
    drive(7'h7D);          // after edge 4: lands in P during the cnt==3 cycle
    tick(3);               // edge 7
    chk("bnd_no_decide_valid",  {31'd0, valid},  32'd0);
    chk("bnd_no_decide_change", {31'd0, change}, 32'd0);
    chk("bnd_no_decide_value",  {28'd0, value},  32'd8);
    tick(3);               // edge 10
    chk("bnd_early_valid", {31'd0, valid}, 32'd0);
    tick(1);               // edge 11
    chk("bnd_value",  {28'd0, value},  32'd6);
    chk("bnd_valid",  {31'd0, valid},  32'd1);
    chk("bnd_change", {31'd0, change}, 32'd1);

    // ---------------- asynchronous reset mid-settle ----------------
    tick(2);
    drive(7'h6F);
    tick(4);
    #3 rst = 1'b1;
    #1;
    chk("areset_value",   {28'd0, value},     32'd0);
    chk("areset_valid",   {31'd0, valid},     32'd0);
    chk("areset_change",  {31'd0, change},    32'd0);
    chk("areset_invalid", {31'd0, invalid},   32'd0);
    chk("areset_err",     {24'd0, err_count}, 32'd0);
    #1 rst = 1'b0;
    tick(6);
    chk("post_reset_early_valid", {31'd0, valid}, 32'd0);
    tick(1);
    chk("post_reset_value",  {28'd0, value},  32'd9);
    chk("post_reset_valid",  {31'd0, valid},  32'd1);
    chk("post_reset_change", {31'd0, change}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_decoder.md
# segment_decoder

Recovers a 4-bit hex value from seven-segment drive lines, the inverse of the `seven_segment` encoder. It synchronizes the seven segment inputs and requires each pattern to hold for a programmable number of cycles. It then decodes the stable pattern to a value and flags blank and unrecognized patterns. It is used as a loopback checker on the display path: the counter drives `seven_segment`, which drives `segment_decoder`, which is compared against the counter. It also serves as a front end for reading external segment displays.

## Interface
- `STABLE_CYCLES`, default 250000: consecutive identical synchronized samples required before a pattern is accepted (10 ms at 25 MHz). Minimum 2.
- `ACTIVE_LOW`, default 1: segment inputs are active-low (Go Board polarity). Set to 0 for active-high inputs.
- `i_Clk` input, 1 bit: system clock, single clock domain.
- `i_Rst` input, 1 bit: asynchronous, active-high reset.
- `i_Seg_A` … `i_Seg_G` input, 1 bit each: segment lines, asynchronous to `i_Clk`.
- `o_Value` output, 4 bits: last accepted digit value.
- `o_Valid` output, 1 bit: high while the last accepted pattern is a legal digit.
- `o_Change` output, 1 bit: one-cycle pulse when a newly accepted digit differs from the previous accepted digit, or is the first digit accepted after reset or after a blank/invalid period.
- `o_Invalid` output, 1 bit: one-cycle pulse when a stable, non-blank, unrecognized pattern is accepted.
- `o_Err_Count` output, 8 bits: count of `o_Invalid` pulses, saturating at 255.

## Operation
- **Synchronizer:** two-flop synchronizer on all 7 lines. Flops reset to the physical "all off" level (1 when `ACTIVE_LOW`=1). The synchronized vector is normalized to active-high pattern `P = {G,F,E,D,C,B,A}`.
- **Stability:** a candidate register and a counter of width `$clog2(STABLE_CYCLES)`.
  - If `P` differs from the candidate: candidate is loaded with `P`, counter is cleared, FSM enters `S_SETTLE`.
  - Otherwise the counter increments, saturating at `STABLE_CYCLES-1`.
- **Decode table** (active-high, hex digits 0–F): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Pattern 00 is blank. Every other pattern is invalid.
- **FSM states:** `S_IDLE`, `S_SETTLE`, `S_DIGIT`, `S_BLANK`, `S_INVALID`.
  - `S_IDLE`: after reset. Behaves as `S_SETTLE` with the candidate equal to blank.
  - `S_SETTLE`: when counter reaches `STABLE_CYCLES-1`, the decision is made from the candidate and the FSM moves to `S_DIGIT`, `S_BLANK` or `S_INVALID`.
  - Decided states (`S_DIGIT`, `S_BLANK`, `S_INVALID`): held until `P` differs from the candidate, then return to `S_SETTLE`.
- **Outputs on decision:**
  - `S_DIGIT`: `o_Value` ← digit, `o_Valid` ← 1, `o_Change` pulses per the rule above.
  - `S_BLANK`: `o_Valid` ← 0, `o_Value` holds, no pulse.
  - `S_INVALID`: `o_Valid` ← 0, `o_Invalid` pulses, `o_Err_Count` increments (saturating).
- **During `S_SETTLE`:** all level outputs hold their previous values. Glitches shorter than `STABLE_CYCLES` never reach the outputs. Re-accepting the same digit produces no `o_Change` pulse.
- **Reset:** `o_Value`=0, `o_Valid`=0, `o_Change`=0, `o_Invalid`=0, `o_Err_Count`=0, state `S_IDLE`, candidate = blank, counter = 0. An assertion mid-settle discards the candidate.
- **Simultaneous events:** a pattern change on the same cycle the counter saturates takes priority. The candidate is reloaded and no decision is made.

## Timing
- Input change is sampled at edge 0. Synchronized `P` is valid after edge 2, and the candidate loads at edge 3.
- The decision is registered at edge `STABLE_CYCLES+3`, so outputs change `STABLE_CYCLES+3` cycles after the input edge.
- `o_Change` and `o_Invalid` are high for exactly one cycle, coincident with the `o_Value`/`o_Valid` update.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Package `segment_pkg`:**
  - the 16 digit pattern constants and the blank constant, shared with `seven_segment` so both directions use one table;
  - FSM state encoding;
  - a `decode_pattern` function returning `{legal, value}`.
- **Sub-module `segment_sync`:** parameterized-width two-flop synchronizer with a reset value parameter. It is reusable by `debounce_module` users.
- **Loopback bench:** instantiates `seven_segment` → `segment_decoder`.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `ACTIVE_LOW`=1.
- **Reset:** assert `i_Rst` asynchronously mid-cycle → all outputs 0 immediately. Inputs held at 7'h7F (blank) after release → `o_Valid` stays 0 and no pulses occur.
- **Digit accept:** drive inverted pattern for 5 (~6D) → exactly 7 cycles later `o_Value`=5, `o_Valid`=1, one-cycle `o_Change`. Re-drive 5 after a 2-cycle glitch to 8 → no output change, no pulse.
- **Loopback:** sweep 0–F through `seven_segment` → `o_Value` tracks each value, 16 `o_Change` pulses, `o_Err_Count`=0.
- **Invalid:** drive active-high 0x01 (A only) stably → `o_Invalid` pulse, `o_Valid`=0, `o_Value` holds the prior digit. 300 such events → `o_Err_Count` saturates at 255.
- **Blank between digits:** 3 → blank → 3 → `o_Valid` goes 1→0→1, and `o_Change` pulses on both acceptances of 3.
- **Boundary:** change the pattern on exactly the cycle the counter saturates → no decision that cycle; the new pattern is accepted 4 cycles after its candidate load.
